flappy_ctrl: RTL and testbench
==============================

FLAPPY_CTRL -- requirements
Module: flappy_ctrl

Interface
REQ-001 SHALL have port clk  in  1  system clock.
REQ-002 SHALL have port reset  in  1  reset: reset, synchronous, active-high; clock clk.
REQ-003 SHALL have port key  in  1  raw asynchronous player button, high = pressed.
REQ-004 SHALL have port birdCol  in  8  bird-column pixel lights, bit 0 = bottom row, one-hot while the bird is alive.
REQ-005 SHALL have port pipeCol  in  8  pipe pixels in the bird column, bit 0 = bottom row.
REQ-006 SHALL have port press  out  1  move-up request to the bird pixels, valid at every tick edge.
REQ-007 SHALL have port ongoing  out  1  game active; low holds the bird pixels at their start position.
REQ-008 SHALL have port gameOver  out  1  freezes the bird pixels.
REQ-009 SHALL have port tick  out  1  one-cycle pulse marking the move edge.
REQ-010 SHALL have port score  out  8  two-digit BCD score, [7:4] tens, [3:0] units.

Function
REQ-011 SHALL pass key through a two-flop synchronizer; keyF = filtered level; rise = keyF & ~keyF_prev.
REQ-012 SHALL implement states IDLE (ongoing=0, gameOver=0), PLAY (ongoing=1, gameOver=0), OVER (ongoing=1, gameOver=1).
REQ-013 IDLE->PLAY on rise; score cleared to 8'h00 on the same edge.
REQ-014 PLAY->OVER on the first cycle with (birdCol & pipeCol) != 0 or birdCol == 0 (bird fell out).
REQ-015 OVER->IDLE on rise; score held unchanged through OVER and IDLE.
REQ-016 Rise and collision in the same PLAY cycle: collision wins; the rise is discarded.
REQ-017 SHALL keep a 7-bit prescaler: held at 0 while ongoing=0, otherwise increments every cycle and wraps 127->0.
REQ-018 tick = ongoing & (prescaler == 0); the first tick occurs in the first PLAY cycle.
REQ-019 Press latch: set in any cycle where keyF=1; cleared on the tick edge unless keyF=1 in that cycle; cleared on entry to PLAY; press = latch, 0 outside PLAY.
REQ-020 A press of one cycle or longer anywhere in a tick period SHALL produce press=1 at the following tick edge and press=0 at the tick edge after that if the key was released.
REQ-021 SHALL register pipeCol into pipePrev on each tick edge in PLAY.
REQ-022 On a tick in PLAY with pipePrev != 0 and pipeCol == 0: score += 1 in BCD; units 9 -> 0 with tens carry; saturate at 8'h99.
REQ-023 Score increment and collision in the same cycle: the state goes to OVER and the score is still incremented.
REQ-024 Latency without debounce: key high before edge N -> rise at edge N+2 -> state change visible after edge N+2.

Reset
REQ-025 reset=1 at a clock edge SHALL force IDLE, press=0, ongoing=0, gameOver=0, tick=0, score=8'h00, prescaler=0, pipePrev=0, synchronizer/filter/latch=0; takes priority over all events, including mid-game.
REQ-026 The first state transition after reset release SHALL require a fresh 0->1 key transition.

Configuration
REQ-027 Macro FLAPPY_KEY_DEBOUNCE_EN defined: keyF SHALL change only after the synchronized key has held a new value for 8 consecutive cycles (3-bit stability counter), adding 8 cycles to REQ-024.
REQ-028 Macro FLAPPY_KEY_DEBOUNCE_EN undefined: keyF = synchronizer output; no counter is instantiated.

Verification
REQ-029 Scenario 1: reset, key pulse 3 cycles, birdCol=8'h10, pipeCol=0 -> ongoing=1 two edges after the key pulse, tick every 128 cycles, gameOver=0.
REQ-030 Scenario 2: in PLAY, key high 1 cycle at prescaler=40 -> press=1 at the next tick edge (prescaler=0), press=0 at the tick after that.
REQ-031 Scenario 3: in PLAY, birdCol=8'h08, pipeCol=8'h08 -> gameOver=1 next cycle, ongoing stays 1; key rise -> IDLE, ongoing=0.
REQ-032 Scenario 4: in PLAY, birdCol driven to 8'h00 -> OVER the next cycle.
REQ-033 Scenario 5: pipeCol=8'hE7 for one tick then 8'h00 at the next tick, repeated 100 times -> score 8'h09 -> 8'h10 carry observed, final 8'h99 (saturated).
REQ-034 Scenario 6: reset asserted mid-PLAY with score=8'h23 -> all outputs 0 after one edge; with FLAPPY_KEY_DEBOUNCE_EN defined, a 5-cycle key glitch causes no transition.

Source files
------------

// File: rtl/flappy_ctrl.sv
// Game-state controller for a single-column flappy-bird display: key sync, FSM, tick, BCD score.
// Optional key debounce is enabled by defining FLAPPY_KEY_DEBOUNCE_EN.
module flappy_ctrl (
   input  logic       clk,
   input  logic       reset,
   input  logic       key,
   input  logic [7:0] birdCol,
   input  logic [7:0] pipeCol,
   output logic       press,
   output logic       ongoing,
   output logic       gameOver,
   output logic       tick,
   output logic [7:0] score
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_PLAY = 2'd1;
   localparam logic [1:0] ST_OVER = 2'd2;

   logic       r_sync1;
   logic       r_sync2;
   logic [1:0] r_settle;
   logic       r_armed;
   logic       r_key_prev;
   logic       w_key_f;
   logic       w_rise;

   logic [1:0] r_state;
   logic [1:0] w_state_next;
   logic [6:0] r_presc;
   logic       r_latch;
   logic [7:0] r_pipe_prev;
   logic [7:0] r_score;
   logic [7:0] w_score_inc;

   logic       w_in_play;
   logic       w_collide;
   logic       w_enter_play;
   logic       w_play_tick;
   logic       w_score_evt;

   // r_armed blocks a key held through reset from looking like a fresh press.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync1    <= 1'b0;
         r_sync2    <= 1'b0;
         r_settle   <= 2'b00;
         r_armed    <= 1'b0;
         r_key_prev <= 1'b0;
      end else begin
         r_sync1    <= key;
         r_sync2    <= r_sync1;
         r_settle   <= {r_settle[0], 1'b1};
         r_key_prev <= w_key_f;
         if (r_settle[1] && !r_sync2) begin
            r_armed <= 1'b1;
         end
      end
   end

`ifdef FLAPPY_KEY_DEBOUNCE_EN
   logic [2:0] r_db_cnt;
   logic       r_key_f;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_db_cnt <= 3'd0;
         r_key_f  <= 1'b0;
      end else if (r_sync2 == r_key_f) begin
         r_db_cnt <= 3'd0;
      end else if (r_db_cnt == 3'd7) begin
         r_key_f  <= r_sync2;
         r_db_cnt <= 3'd0;
      end else begin
         r_db_cnt <= r_db_cnt + 3'd1;
      end
   end

   assign w_key_f = r_key_f;
`else
   assign w_key_f = r_sync2;
`endif

   assign w_rise       = w_key_f & ~r_key_prev & r_armed;
   assign w_in_play    = (r_state == ST_PLAY);
   assign w_collide    = ((birdCol & pipeCol) != 8'h00) || (birdCol == 8'h00);
   assign w_enter_play = (r_state == ST_IDLE) && w_rise;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: if (w_rise) w_state_next = ST_PLAY;
         ST_PLAY: if (w_collide) w_state_next = ST_OVER;
         ST_OVER: if (w_rise) w_state_next = ST_IDLE;
         default: w_state_next = ST_IDLE;
      endcase
   end

   assign ongoing     = (r_state != ST_IDLE);
   assign gameOver    = (r_state == ST_OVER);
   assign tick        = ongoing && (r_presc == 7'd0);
   assign press       = r_latch & w_in_play;
   assign score       = r_score;
   assign w_play_tick = w_in_play & tick;
   assign w_score_evt = w_play_tick && (r_pipe_prev != 8'h00) && (pipeCol == 8'h00);

   // Saturating two-digit BCD increment.
   always_comb begin
      w_score_inc = r_score;
      if (r_score == 8'h99) begin
         w_score_inc = 8'h99;
      end else if (r_score[3:0] == 4'd9) begin
         w_score_inc = {r_score[7:4] + 4'd1, 4'd0};
      end else begin
         w_score_inc = {r_score[7:4], r_score[3:0] + 4'd1};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_presc     <= 7'd0;
         r_latch     <= 1'b0;
         r_pipe_prev <= 8'h00;
         r_score     <= 8'h00;
      end else begin
         r_state <= w_state_next;
         r_presc <= ongoing ? r_presc + 7'd1 : 7'd0;

         if (w_enter_play) begin
            r_latch <= 1'b0;
         end else if (w_key_f) begin
            r_latch <= 1'b1;
         end else if (tick) begin
            r_latch <= 1'b0;
         end

         if (w_play_tick) begin
            r_pipe_prev <= pipeCol;
         end

         if (w_enter_play) begin
            r_score <= 8'h00;
         end else if (w_score_evt) begin
            r_score <= w_score_inc;
         end
      end
   end

endmodule

// File: tb/tb_flappy_ctrl.sv
// Self-checking bench for flappy_ctrl: scoreboarded output snapshots, a collision vector table,
// and hand-written sequences for start latency, ticks, press latch, scoring and reset.
module tb_flappy_ctrl;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       key     = 1'b0;
   logic [7:0] birdCol = 8'h10;
   logic [7:0] pipeCol = 8'h00;
   logic       press;
   logic       ongoing;
   logic       gameOver;
   logic       tick;
   logic [7:0] score;

   always #5 clk = ~clk;

   flappy_ctrl dut (
      .clk      (clk),
      .reset    (reset),
      .key      (key),
      .birdCol  (birdCol),
      .pipeCol  (pipeCol),
      .press    (press),
      .ongoing  (ongoing),
      .gameOver (gameOver),
      .tick     (tick),
      .score    (score)
   );

   // Snapshot layout: {press, ongoing, gameOver, tick, score[7:0]}
   localparam logic [11:0] M_P   = 12'h800;
   localparam logic [11:0] M_ON  = 12'h400;
   localparam logic [11:0] M_GO  = 12'h200;
   localparam logic [11:0] M_TK  = 12'h100;
   localparam logic [11:0] M_SC  = 12'h0FF;
   localparam logic [11:0] M_ALL = 12'hFFF;

   typedef struct {
      string       name;
      logic [11:0] exp;
      logic [11:0] mask;
   } sb_t;

   typedef struct {
      string      name;
      logic [7:0] bird;
      logic [7:0] pipe;
      logic       over;
   } col_t;

   sb_t  sb_q[$];
   col_t col_tab[7];
   int   n_pass  = 0;
   int   n_total = 0;

   function automatic logic [11:0] outs(logic p, logic on, logic go, logic tk, logic [7:0] sc);
      return {p, on, go, tk, sc};
   endfunction

   function automatic logic [7:0] bcd(int n);
      int         v;
      logic [3:0] t;
      logic [3:0] u;
      v = (n > 99) ? 99 : n;
      t = 4'(v / 10);
      u = 4'(v % 10);
      return {t, u};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(string nm, logic [11:0] e, logic [11:0] m);
      sb_q.push_back('{nm, e, m});
   endtask

   task automatic sb_check();
      sb_t         s;
      logic [11:0] act;
      while (sb_q.size() > 0) begin
         s   = sb_q.pop_front();
         act = {press, ongoing, gameOver, tick, score};
         n_total++;
         if ((act & s.mask) === (s.exp & s.mask)) begin
            n_pass++;
         end else begin
            $display("FAIL %s: got p/on/go/tk/score=%b/%b/%b/%b/%h, expected %b/%b/%b/%b/%h (mask %h)",
                     s.name, act[11], act[10], act[9], act[8], act[7:0],
                     s.exp[11], s.exp[10], s.exp[9], s.exp[8], s.exp[7:0], s.mask);
         end
      end
   endtask

   task automatic check_now(string nm, logic [11:0] e, logic [11:0] m);
      expect_out(nm, e, m);
      sb_check();
   endtask

   task automatic chk_int(string nm, int act, int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
   endtask

   task automatic wait_tick(output int cycles);
      cycles = 0;
      do begin
         step();
         cycles++;
      end while (!tick && cycles < 300);
      n_total++;
      if (tick) n_pass++;
      else $display("FAIL tick_timeout: no tick after %0d cycles, expected within 128", cycles);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      repeat (4) step();
   endtask

   // One-cycle key pulse; a rise lands two edges later, the state change on the third edge.
   task automatic key_pulse();
      key = 1'b1;
      step();
      key = 1'b0;
      step();
      step();
   endtask

   task automatic start_game(string nm);
      key = 1'b1;
      step();
      key = 1'b0;
      step();
      check_now({nm, "_pre"}, outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ON);
      step();
      check_now({nm, "_start"}, outs(1'b0, 1'b1, 1'b0, 1'b1, 8'h00), M_ALL);
   endtask

   task automatic end_game(string nm);
      birdCol = 8'h00;
      pipeCol = 8'h00;
      step();
      key_pulse();
      birdCol = 8'h10;
      check_now({nm, "_idle"}, outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ON | M_GO);
   endtask

   // Pipe column present at one tick, clear at the next: one point scored.
   task automatic score_pair();
      int c;
      pipeCol = 8'hE7;
      wait_tick(c);
      step();
      pipeCol = 8'h00;
      wait_tick(c);
      step();
   endtask

   initial begin
      int c;

      col_tab[0] = '{"hit_08",   8'h08, 8'h08, 1'b1};
      col_tab[1] = '{"fell_00",  8'h00, 8'h00, 1'b1};
      col_tab[2] = '{"clear_10", 8'h10, 8'h00, 1'b0};
      col_tab[3] = '{"gap_01",   8'h01, 8'hFE, 1'b0};
      col_tab[4] = '{"hit_80",   8'h80, 8'h80, 1'b1};
      col_tab[5] = '{"fell_ff",  8'h00, 8'hFF, 1'b1};
      col_tab[6] = '{"gap_04",   8'h04, 8'hFB, 1'b0};

      repeat (3) step();
      check_now("reset_state", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ALL);
      reset = 1'b0;
      repeat (4) step();
      check_now("idle_after_reset", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ALL);

`ifdef FLAPPY_KEY_DEBOUNCE_EN
      key = 1'b1;
      repeat (5) step();
      key = 1'b0;
      repeat (20) step();
      check_now("db_glitch5", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ALL);
      key = 1'b1;
      repeat (10) step();
      check_now("db_pre", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ON);
      key = 1'b0;
      step();
      check_now("db_start", outs(1'b0, 1'b1, 1'b0, 1'b1, 8'h00), M_ON | M_GO | M_TK | M_SC);
      reset = 1'b1;
      step();
      check_now("db_reset", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ALL);
      key = 1'b1;
      step();
      reset = 1'b0;
      repeat (30) step();
      check_now("db_held_key", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ON);
      key = 1'b0;
`else
      // Start with a 3-cycle pulse, then tick spacing and press latched in the first PLAY cycle.
      key = 1'b1;
      step();
      step();
      check_now("s1_not_yet", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ALL);
      step();
      key = 1'b0;
      check_now("s1_start", outs(1'b0, 1'b1, 1'b0, 1'b1, 8'h00), M_ALL);
      wait_tick(c);
      chk_int("s1_tick_period_a", c, 128);
      check_now("s1_press_tick2", outs(1'b1, 1'b1, 1'b0, 1'b1, 8'h00), M_ALL);
      wait_tick(c);
      chk_int("s1_tick_period_b", c, 128);
      check_now("s1_press_tick3", outs(1'b0, 1'b1, 1'b0, 1'b1, 8'h00), M_ALL);

      // One-cycle press mid-period.
      repeat (40) step();
      key = 1'b1;
      step();
      key = 1'b0;
      wait_tick(c);
      check_now("s2_press_set", outs(1'b1, 1'b0, 1'b0, 1'b1, 8'h00), M_P | M_TK);
      wait_tick(c);
      check_now("s2_press_clr", outs(1'b0, 1'b0, 1'b0, 1'b1, 8'h00), M_P | M_TK);

      for (int i = 0; i < 100; i++) begin
         score_pair();
         check_now($sformatf("s5_score_%0d", i + 1),
                   outs(1'b0, 1'b1, 1'b0, 1'b0, bcd(i + 1)), M_ON | M_GO | M_SC);
      end

      birdCol = 8'h00;
      step();
      check_now("s4_fell_over", outs(1'b0, 1'b1, 1'b1, 1'b0, 8'h99), M_ALL);
      key_pulse();
      check_now("over_to_idle", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h99), M_ALL);
      birdCol = 8'h10;
      repeat (5) step();
      check_now("idle_score_held", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h99), M_ALL);

      foreach (col_tab[i]) begin
         start_game(col_tab[i].name);
         repeat (3) step();
         birdCol = col_tab[i].bird;
         pipeCol = col_tab[i].pipe;
         expect_out({col_tab[i].name, "_a"}, outs(1'b0, 1'b1, col_tab[i].over, 1'b0, 8'h00),
                    M_ON | M_GO | M_SC);
         step();
         sb_check();
         expect_out({col_tab[i].name, "_b"}, outs(1'b0, 1'b1, col_tab[i].over, 1'b0, 8'h00),
                    M_ON | M_GO);
         step();
         sb_check();
         end_game(col_tab[i].name);
      end

      // Score increment and fall in the same tick cycle.
      start_game("inc_col");
      pipeCol = 8'hE7;
      wait_tick(c);
      step();
      pipeCol = 8'h00;
      wait_tick(c);
      birdCol = 8'h00;
      step();
      check_now("inc_and_collide", outs(1'b0, 1'b1, 1'b1, 1'b0, 8'h01), M_ALL);
      key_pulse();
      birdCol = 8'h10;
      check_now("inc_col_idle", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h01), M_ALL);

      // Rise and collision in the same PLAY cycle: OVER, and the rise must not also end the game.
      start_game("rise_col");
      repeat (3) step();
      key = 1'b1;
      step();
      key = 1'b0;
      step();
      birdCol = 8'h08;
      pipeCol = 8'h08;
      step();
      check_now("rise_col_over", outs(1'b0, 1'b1, 1'b1, 1'b0, 8'h00), M_ON | M_GO);
      step();
      step();
      check_now("rise_discarded", outs(1'b0, 1'b1, 1'b1, 1'b0, 8'h00), M_ON | M_GO);
      end_game("rise_col");

      start_game("s6");
      for (int i = 0; i < 23; i++) score_pair();
      check_now("s6_score_23", outs(1'b0, 1'b1, 1'b0, 1'b0, 8'h23), M_ON | M_GO | M_SC);
      reset = 1'b1;
      step();
      check_now("s6_reset_midplay", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ALL);

      // Key held through reset release must not start a game.
      key = 1'b1;
      step();
      reset = 1'b0;
      repeat (12) step();
      check_now("held_key_no_start", outs(1'b0, 1'b0, 1'b0, 1'b0, 8'h00), M_ALL);
      key = 1'b0;
      repeat (4) step();
      start_game("fresh_edge");
      end_game("fresh_edge");
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
